// File: rtl/register_pipeline_pkg.sv
// register_pipeline_pkg: shared types and sizing helpers for the register pipeline
package register_pipeline_pkg;
  localparam int MAX_WORD_WIDTH = 64;
  typedef struct packed {
    logic                      valid;
    logic [MAX_WORD_WIDTH-1:0] data;
  } stage_t;
  function automatic int occ_width(input int depth);
    return $clog2(depth + 1);
  endfunction
endpackage

// File: rtl/register_pipeline_stage.sv
// register_pipeline_stage: one valid+data register slot with async reset, sync clear and load enable
module register_pipeline_stage #(
  parameter int                    WORD_WIDTH  = 8,
  parameter logic [WORD_WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  load,
  input  logic                  next_valid,
  input  logic [WORD_WIDTH-1:0] next_data,
  output logic                  valid,
  output logic [WORD_WIDTH-1:0] data
);
  // data only moves with a valid word so an emptied slot keeps its last value
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      valid <= 1'b0;
      data  <= RESET_VALUE;
    end else if (clear) begin
      valid <= 1'b0;
      data  <= RESET_VALUE;
    end else if (load) begin
      valid <= next_valid;
      if (next_valid) data <= next_data;
    end
endmodule

// File: rtl/register_pipeline.sv
// register_pipeline: DEPTH-stage valid/ready register pipeline; REGISTER_PIPELINE_OCCUPANCY_EN adds an occupancy counter port
module register_pipeline
  import register_pipeline_pkg::*;
#(
  parameter int                    WORD_WIDTH  = 8,
  parameter int                    DEPTH       = 2,
  parameter logic [WORD_WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         clear,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [WORD_WIDTH-1:0]        in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [WORD_WIDTH-1:0]        out_data
`ifdef REGISTER_PIPELINE_OCCUPANCY_EN
  ,
  output logic [occ_width(DEPTH)-1:0]  occupancy
`endif
);
  logic [DEPTH:0]          chain_valid;
  logic [WORD_WIDTH-1:0]   chain_data [DEPTH+1];
  logic [DEPTH:0]          ready;
  assign ready[DEPTH]   = out_ready;
  assign in_ready       = ready[0] && !clear;
  assign chain_valid[0] = in_valid && in_ready;
  assign chain_data[0]  = in_data;
  assign out_valid      = chain_valid[DEPTH];
  assign out_data       = chain_data[DEPTH];
  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    assign ready[i] = !chain_valid[i+1] || ready[i+1];
    register_pipeline_stage #(
      .WORD_WIDTH (WORD_WIDTH),
      .RESET_VALUE(RESET_VALUE)
    ) u_stage (
      .clock     (clock),
      .reset     (reset),
      .clear     (clear),
      .load      (ready[i]),
      .next_valid(chain_valid[i]),
      .next_data (chain_data[i]),
      .valid     (chain_valid[i+1]),
      .data      (chain_data[i+1])
    );
  end
`ifdef REGISTER_PIPELINE_OCCUPANCY_EN
  localparam int OW = occ_width(DEPTH);
  logic in_fire, out_fire;
  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;
  // counts words held; simultaneous in/out cancels out
  always_ff @(posedge clock or posedge reset)
    if (reset) occupancy <= '0;
    else if (clear) occupancy <= '0;
    else occupancy <= occupancy + OW'(in_fire) - OW'(out_fire);
`endif
endmodule

// File: tb/tb_register_pipeline.sv
// tb_register_pipeline: scoreboard bench for register_pipeline (DEPTH=3, WORD_WIDTH=8)
module tb_register_pipeline;
  import register_pipeline_pkg::*;
  localparam int W = 8;
  localparam int D = 3;
  localparam logic [W-1:0] RV = 8'hA5;
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic clear = 1'b0;
  logic in_valid = 1'b0;
  logic in_ready;
  logic [W-1:0] in_data = '0;
  logic out_valid;
  logic out_ready = 1'b0;
  logic [W-1:0] out_data;
`ifdef REGISTER_PIPELINE_OCCUPANCY_EN
  logic [occ_width(D)-1:0] occupancy;
`endif
  int tests = 0;
  int fails = 0;
  logic [W-1:0] sb [$];
  stage_t snap;
  logic snap_ready;

  always #5 clock = ~clock;

  register_pipeline #(.WORD_WIDTH(W), .DEPTH(D), .RESET_VALUE(RV)) dut (
    .clock    (clock),
    .reset    (reset),
    .clear    (clear),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data)
`ifdef REGISTER_PIPELINE_OCCUPANCY_EN
    ,
    .occupancy(occupancy)
`endif
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // sample the cycle at the falling edge, record the accepted word just after
  task automatic tick();
    logic f;
    @(negedge clock);
    f = in_valid && in_ready;
    snap.valid = out_valid;
    snap.data = 64'(out_data);
    snap_ready = in_ready;
    #1;
    if (f) sb.push_back(in_data);
    @(posedge clock);
    #1;
  endtask

  // monitor: every output handshake must match the oldest expected word
  always @(negedge clock) begin
    if (!reset && !clear) begin
`ifdef REGISTER_PIPELINE_OCCUPANCY_EN
      chk("occupancy", 64'(occupancy), 64'(sb.size()));
`endif
      if (out_valid && out_ready) begin
        if (sb.size() == 0) chk("sb_nonempty_at_out", 64'(sb.size() != 0), 1);
        else chk("out_data", 64'(out_data), 64'(sb.pop_front()));
      end
    end
  end

  initial begin
    repeat (2) @(posedge clock);
    #1;
    chk("rst_out_valid", 64'(out_valid), 0);
    chk("rst_out_data", 64'(out_data), 64'(RV));
    chk("rst_in_ready", 64'(in_ready), 1);
    reset = 1'b0;
    // latency and throughput
    out_ready = 1'b1;
    in_valid = 1'b1; in_data = 8'h11; tick(); chk("a_c0_ov", 64'(snap.valid), 0);
    in_data = 8'h22; tick();
    in_data = 8'h33; tick(); chk("a_c2_ov", 64'(snap.valid), 0);
    in_valid = 1'b0; tick(); chk("a_c3_ov", 64'(snap.valid), 1); chk("a_c3_data", snap.data, 64'h11);
    tick(); chk("a_c4_data", snap.data, 64'h22);
    tick(); chk("a_c5_data", snap.data, 64'h33);
    tick(); chk("a_c6_ov", 64'(snap.valid), 0);
    // backpressure: fill, stall, pass-through when full
    out_ready = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_data = 8'hB0 + W'(i);
      tick();
      chk("b_accept", 64'(snap_ready), 1);
    end
    in_data = 8'hB3; tick();
    chk("b_full_ready", 64'(snap_ready), 0);
    chk("b_full_data", snap.data, 64'hB0);
`ifdef REGISTER_PIPELINE_OCCUPANCY_EN
    chk("b_occ", 64'(occupancy), 3);
`endif
    tick();
    chk("b_hold_ov", 64'(snap.valid), 1);
    chk("b_hold_data", snap.data, 64'hB0);
    out_ready = 1'b1; tick();
    chk("b_full_pass", 64'(snap_ready), 1);
    in_valid = 1'b0;
    repeat (4) tick();
    chk("b_drained", 64'(snap.valid), 0);
    // clear with a full pipe and a pending input
    out_ready = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_data = 8'hC0 + W'(i);
      tick();
    end
    in_data = 8'hC3; clear = 1'b1; out_ready = 1'b1; tick();
    chk("c_clear_ready", 64'(snap_ready), 0);
    sb.delete();
    clear = 1'b0; in_valid = 1'b0; tick();
    chk("c_after_ov", 64'(snap.valid), 0);
    chk("c_after_data", snap.data, 64'(RV));
    // asynchronous reset with two words in flight
    out_ready = 1'b0; in_valid = 1'b1;
    in_data = 8'hD0; tick();
    in_data = 8'hD1; tick();
    in_valid = 1'b0; tick();
    chk("d_pre_ov", 64'(out_valid), 1);
    #2 reset = 1'b1;
    #1;
    chk("d_rst_ov", 64'(out_valid), 0);
    chk("d_rst_data", 64'(out_data), 64'(RV));
    chk("d_rst_in_ready", 64'(in_ready), 1);
    sb.delete();
    @(posedge clock);
    #1 reset = 1'b0;
    out_ready = 1'b1; in_valid = 1'b1; in_data = 8'h5A; tick();
    in_valid = 1'b0; tick();
    tick(); chk("d_c2_ov", 64'(snap.valid), 0);
    tick(); chk("d_c3_ov", 64'(snap.valid), 1); chk("d_c3_data", snap.data, 64'h5A);
    // random handshakes
    for (int i = 0; i < 10000; i++) begin
      in_valid = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      in_data = W'($urandom);
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (D + 2) tick();
    chk("e_sb_empty", 64'(sb.size()), 0);
    chk("e_drained_ov", 64'(out_valid), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/register_pipeline.md
REGISTER_PIPELINE -- requirements
Module: register_pipeline

Interface
REQ-001 SHALL have parameter WORD_WIDTH, default 8, data width in bits (>=1).
REQ-002 SHALL have parameter DEPTH, default 2, number of register stages (>=1).
REQ-003 SHALL have parameter RESET_VALUE, default 0, data value after reset or clear.
REQ-004 SHALL have port clock  input  1  single clock; all state on rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port clear  input  1  synchronous, active-high flush of all stages.
REQ-007 SHALL have port in_valid  input  1  upstream word present.
REQ-008 SHALL have port in_ready  output  1  pipeline accepts a word this cycle.
REQ-009 SHALL have port in_data  input  WORD_WIDTH  upstream word.
REQ-010 SHALL have port out_valid  output  1  last stage holds a word.
REQ-011 SHALL have port out_ready  input  1  downstream accepts a word.
REQ-012 SHALL have port out_data  output  WORD_WIDTH  last-stage word.
REQ-013 SHALL have port occupancy  output  $clog2(DEPTH+1)  valid stage count (present only with REGISTER_PIPELINE_OCCUPANCY_EN).

Function
REQ-014 SHALL hold per stage i (0..DEPTH-1) one valid bit and one WORD_WIDTH data register; stage DEPTH-1 drives out_valid/out_data.
REQ-015 SHALL compute stage-i ready = !valid_i || ready_(i+1), with ready_DEPTH = out_ready; in_ready = ready_0 && !clear.
REQ-016 SHALL transfer on handshake only: input when in_valid && in_ready, output when out_valid && out_ready.
REQ-017 SHALL, when stage i is ready, load valid_i <= valid_(i-1) (in_valid && in_ready for i=0) and load data_i only when the incoming valid is 1; data of an emptied stage holds its last value.
REQ-018 SHALL give latency exactly DEPTH cycles from input handshake to out_valid with out_ready held high, and sustain one word per cycle.
REQ-019 SHALL preserve order; no word dropped or duplicated under any in_valid/out_ready pattern.
REQ-020 SHALL, when full (all valid) and out_ready=0, deassert in_ready and hold all stages unchanged.
REQ-021 SHALL, when full and out_ready=1, accept a new input in the same cycle (in_ready=1, combinational ready chain).
REQ-022 SHALL keep out_data stable while out_valid=1 and out_ready=0.
REQ-023 SHALL, on clear, set all valid bits to 0 and all data to RESET_VALUE at the next edge; clear dominates any simultaneous input or output handshake; in_ready=0 while clear=1.

Reset
REQ-024 SHALL on reset asynchronously set all valid bits 0, all data RESET_VALUE, occupancy 0; out_valid=0, out_data=RESET_VALUE.
REQ-025 SHALL discard words in flight when reset asserts mid-operation; in_ready SHALL be 1 while reset is high and clear is 0 (all stages empty).

Configuration
REQ-026 SHALL, with REGISTER_PIPELINE_OCCUPANCY_EN defined, provide a registered occupancy counter: +1 on input-only handshake, -1 on output-only, unchanged on both or neither, 0 on clear/reset; range 0..DEPTH.
REQ-027 SHALL, without REGISTER_PIPELINE_OCCUPANCY_EN, omit the occupancy port and counter entirely; all other behaviour identical.

Structure
REQ-028 SHALL place the occupancy width function and a stage struct typedef (valid, data) in package register_pipeline_pkg.
REQ-029 SHALL implement each stage as sub-module register_pipeline_stage (valid+data registers, async reset, sync clear, load enable), instantiated DEPTH times by generate loop.

Verification
REQ-030 SHALL cover: DEPTH=3, WORD_WIDTH=8, out_ready=1, inputs 0x11,0x22,0x33 on consecutive cycles -> out 0x11 at cycle 3, 0x22 at 4, 0x33 at 5.
REQ-031 SHALL cover: DEPTH=3, out_ready=0, four in_valid attempts -> three accepted, in_ready=0 on fourth, occupancy=3; out_ready=1 -> 4th accepted same cycle.
REQ-032 SHALL cover: random in_valid/out_ready at 50% for 10000 cycles -> scoreboard order match, no loss, occupancy equals scoreboard depth.
REQ-033 SHALL cover: clear asserted with pipeline full and in_valid=1 -> next cycle out_valid=0, out_data=RESET_VALUE, occupancy=0, input not accepted.
REQ-034 SHALL cover: reset asserted mid-clock with 2 words in flight -> outputs reset immediately without clock edge; after release first new word exits after DEPTH cycles.
REQ-035 SHALL cover: DEPTH=1 build with and without REGISTER_PIPELINE_OCCUPANCY_EN -> identical data/handshake traces.
